ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 201 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One shift-add or restoring-divide step per cycle; stalls the pipe while busy.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic             neg_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;

    logic             accept;
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_d;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] special_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_d;
    logic [WIDTH-1:0] mul_lo_d;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_acc_d;
    logic [WIDTH-1:0] div_lo_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] lo_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   mul_res;
    logic [WIDTH-1:0]   div_raw;
    logic [WIDTH-1:0]   div_res;
    logic [WIDTH-1:0]   final_res;

    assign accept = (state_q == IDLE) && start_i && !flush_i;

    // Stall request: the accept cycle plus every iteration cycle.
    assign busy_o = !rst && (accept || (state_q == BUSY));
    assign done_o = done_q;
    assign result_o = result_q;

    // Decode operand signedness and magnitudes for the incoming op.
    always_comb begin
        is_div   = funct3_i[2];
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (is_div) begin
            a_signed = !funct3_i[0];
            b_signed = !funct3_i[0];
        end else begin
            a_signed = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
            b_signed = (funct3_i[1:0] == 2'b01);
        end
        sa    = a_signed && rs1_i[WIDTH-1];
        sb    = b_signed && rs2_i[WIDTH-1];
        mag_a = sa ? -rs1_i : rs1_i;
        mag_b = sb ? -rs2_i : rs2_i;
        // Remainder follows the dividend; everything else follows sign xor.
        if (is_div && funct3_i[1]) begin
            neg_d = sa;
        end else begin
            neg_d = sa ^ sb;
        end
    end

    // Division corner cases that finish without iterating.
    always_comb begin
        div_zero    = is_div && (rs2_i == '0);
        div_ovf     = is_div && !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3_i[1] ? rs1_i : '1;
        end else begin
            special_res = funct3_i[1] ? '0 : rs1_i;
        end
    end

    // One shift-add multiply step: {acc,lo} holds partial product and multiplier.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_acc_d = mul_sum[WIDTH:1];
        mul_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // One restoring divide step: acc is the remainder, lo shifts dividend to quotient.
    always_comb begin
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_ok    = !div_diff[WIDTH];
        div_acc_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_d  = {lo_q[WIDTH-2:0], div_ok};
    end

    // Pick the step for the latched op and form the signed final result.
    always_comb begin
        acc_d     = op_q[2] ? div_acc_d : mul_acc_d;
        lo_d      = op_q[2] ? div_lo_d : mul_lo_d;
        prod      = {acc_d, lo_d};
        prod_s    = neg_q ? -prod : prod;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        div_raw   = op_q[1] ? acc_d : lo_d;
        div_res   = neg_q ? -div_raw : div_raw;
        final_res = op_q[2] ? div_res : mul_res;
    end

    // Control FSM with datapath registers and registered done/result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q  <= funct3_i;
                        neg_q <= neg_d;
                        acc_q <= '0;
                        cnt_q <= '0;
                        b_q   <= is_div ? mag_b : mag_a;
                        lo_q  <= is_div ? mag_a : mag_b;
                        if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        if (cnt_q == LAST) begin
                            cnt_q    <= '0;
                            result_q <= final_res;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M corners, flush/reset aborts,
// and random ops against a 64-bit arithmetic reference model.
module tb_ex_muldiv;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [2:0]   funct3_i;
    logic [W-1:0] rs1_i;
    logic [W-1:0] rs2_i;
    logic         flush_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;

    int checks = 0;
    int errors = 0;

    ex_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, scramble inputs after accept, and check latency/result.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int lat;
        int busy_cnt;
        bit special;
        exp     = model(f, a, b);
        special = f[2] && ((b == 0) || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        #1;
        check({name, "_busy_accept"}, 32'(busy_o), 32'd1);
        lat      = 0;
        busy_cnt = 1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            rs1_i    = $urandom;
            rs2_i    = $urandom;
            funct3_i = 3'($urandom);
            if (done_o) break;
            if (busy_o) busy_cnt++;
        end
        check({name, "_latency"}, 32'(lat), special ? 32'd1 : 32'd33);
        check({name, "_busy_cycles"}, 32'(busy_cnt), special ? 32'd1 : 32'd33);
        check({name, "_result"}, result_o, exp);
        check({name, "_busy_in_done"}, 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        check({name, "_single_pulse"}, 32'(done_o), 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        logic [31:0] prev;
        int n_done;
        int n_busy;
        rst      = 1'b1;
        start_i  = 1'b0;
        funct3_i = 3'd0;
        rs1_i    = '0;
        rs2_i    = '0;
        flush_i  = 1'b0;
        #1;
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mul_value", result_o, 32'hFFFF_FFEB);
        run_op("mulh", 3'd1, MIN_NEG, MIN_NEG);
        check("mulh_value", result_o, 32'h4000_0000);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu_value", result_o, 32'hFFFF_FFFE);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhsu_value", result_o, 32'hFFFF_FFFF);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
        check("div_value", result_o, 32'hFFFF_FFFD);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
        check("rem_value", result_o, 32'hFFFF_FFFF);
        run_op("divu", 3'd5, 32'd100, 32'd7);
        check("divu_value", result_o, 32'd14);
        run_op("remu", 3'd7, 32'd100, 32'd7);
        check("remu_value", result_o, 32'd2);
        run_op("divu0", 3'd5, 32'd5, 32'd0);
        check("divu0_value", result_o, 32'hFFFF_FFFF);
        run_op("rem0", 3'd6, 32'd5, 32'd0);
        check("rem0_value", result_o, 32'd5);
        run_op("divovf", 3'd4, MIN_NEG, 32'hFFFF_FFFF);
        check("divovf_value", result_o, MIN_NEG);
        run_op("removf", 3'd6, MIN_NEG, 32'hFFFF_FFFF);
        check("removf_value", result_o, 32'd0);

        // Flush alongside start in IDLE must not accept.
        @(negedge clk);
        start_i = 1'b1;
        flush_i = 1'b1;
        #1;
        check("flush_idle_busy", 32'(busy_o), 32'd0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        flush_i = 1'b0;
        #1;
        check("flush_idle_stay", 32'(busy_o), 32'd0);

        // Flush in the middle of a multiply.
        run_op("pre", 3'd0, 32'd3, 32'd5);
        prev = result_o;
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'd0;
        rs1_i    = 32'd7;
        rs2_i    = 32'd9;
        repeat (10) @(posedge clk);
        #2;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("flush_busy", 32'(busy_o), 32'd0);
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) n_done++;
            if (busy_o) n_busy++;
        end
        check("flush_no_done", 32'(n_done), 32'd0);
        check("flush_idle", 32'(n_busy), 32'd0);
        check("flush_result_kept", result_o, prev);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        start_i  = 1'b1;
        funct3_i = 3'd0;
        rs1_i    = 32'd11;
        rs2_i    = 32'd13;
        repeat (5) @(posedge clk);
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_done", 32'(done_o), 32'd0);
        check("arst_result", result_o, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        n_busy = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done_o) n_done++;
            if (busy_o) n_busy++;
        end
        check("arst_no_done", 32'(n_done), 32'd0);
        check("arst_idle", 32'(n_busy), 32'd0);

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            run_op("rand", 3'($urandom), pick(), pick());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
